breath_ctrl: RTL



---
 rtl/breath_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/breath_ctrl.sv
// Breathing-light sequencer: ramps a PWM duty up, holds, ramps down, holds,
// then steps the colour index. Single clock, async active-low reset.
module breath_ctrl #(
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_PERIODS = 64
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                next_i,
    output logic                pwm_o,
    output logic [PWM_BITS-1:0] duty_o,
    output logic [2:0]          color_o,
    output logic                color_adv_o
);
    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam int SW = $clog2(STEP_PERIODS + 1);
    localparam int HW = $clog2(HOLD_PERIODS + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);

    typedef enum logic [2:0] {IDLE, RISE, HOLD_HI, FALL, HOLD_LO} state_t;

    state_t              state, state_nx;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_nx, duty_nx;
    logic [SW-1:0]       step_cnt, step_nx;
    logic [HW-1:0]       hold_cnt, hold_nx;
    logic [2:0]          color_nx;
    logic                pwm_nx, adv_nx;
    logic                period_end, step_evt;

    assign period_end = (pwm_cnt == MAX);
    assign step_evt   = period_end && (step_cnt == STEP_LAST);

    always_comb begin
        state_nx   = state;
        pwm_cnt_nx = pwm_cnt + 1'b1;
        duty_nx    = duty_o;
        step_nx    = step_cnt;
        hold_nx    = hold_cnt;
        color_nx   = color_o;
        adv_nx     = 1'b0;
        pwm_nx     = (pwm_cnt < duty_o);

        case (state)
            IDLE: begin
                pwm_cnt_nx = '0;
                duty_nx    = '0;
                pwm_nx     = 1'b0;
                state_nx   = RISE;
            end
            RISE: begin
                if (next_i) begin
                    state_nx = FALL;
                end else if (period_end) begin
                    step_nx = step_evt ? '0 : step_cnt + 1'b1;
                    if (step_evt) begin
                        if (duty_o >= MAX - 1'b1) begin
                            duty_nx  = MAX;
                            state_nx = HOLD_HI;
                        end else begin
                            duty_nx = duty_o + 1'b1;
                        end
                    end
                end
            end
            HOLD_HI: begin
                if (next_i) begin
                    state_nx = FALL;
                end else if (period_end) begin
                    if (hold_cnt == HOLD_LAST) state_nx = FALL;
                    else                       hold_nx  = hold_cnt + 1'b1;
                end
            end
            FALL: begin
                if (period_end) begin
                    step_nx = step_evt ? '0 : step_cnt + 1'b1;
                    // <= 1 also covers an early abort out of RISE at duty 0
                    if (step_evt) begin
                        if (duty_o <= PWM_BITS'(1)) begin
                            duty_nx  = '0;
                            state_nx = HOLD_LO;
                        end else begin
                            duty_nx = duty_o - 1'b1;
                        end
                    end
                end
            end
            HOLD_LO: begin
                if (period_end) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nx = RISE;
                        color_nx = (color_o == 3'd5) ? 3'd0 : color_o + 3'd1;
                        adv_nx   = 1'b1;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state_nx != state) begin
            step_nx = '0;
            hold_nx = '0;
        end

        // disable wins over everything; colour is kept for the next enable
        if (!en_i) begin
            state_nx   = IDLE;
            pwm_cnt_nx = '0;
            duty_nx    = '0;
            step_nx    = '0;
            hold_nx    = '0;
            pwm_nx     = 1'b0;
            color_nx   = color_o;
            adv_nx     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            pwm_cnt     <= '0;
            step_cnt    <= '0;
            hold_cnt    <= '0;
            duty_o      <= '0;
            pwm_o       <= 1'b0;
            color_o     <= 3'd0;
            color_adv_o <= 1'b0;
        end else begin
            state       <= state_nx;
            pwm_cnt     <= pwm_cnt_nx;
            step_cnt    <= step_nx;
            hold_cnt    <= hold_nx;
            duty_o      <= duty_nx;
            pwm_o       <= pwm_nx;
            color_o     <= color_nx;
            color_adv_o <= adv_nx;
        end
    end
endmodule
